alu_arbiter: RTL

- Shares the single 8-bit ALU between two requesters, e.g. the PC-increment path (port 0) and the execute stage (port 1).
- Arbitrates round-robin and registers the winner's operands and opcode onto the ALU inputs.
- Captures the ALU result and flags one cycle later and returns them with a done pulse tagged by requester.
- Rejects unsupported opcodes with an error pulse instead of using the ALU output.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one ALU between two requesters.
// Define ALU_ARB_BACK2BACK_EN to arbitrate in RESP (1 op / 2 cycles). Rev 1.0
// ============================================================================
module alu_arbiter #(
  parameter int W      = 8,
  parameter int OPW    = 4,
  parameter int MAX_OP = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [OPW-1:0] op0,
  input  logic [OPW-1:0] op1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done,
  output logic           done_id,
  output logic [W-1:0]   res,
  output logic           res_zero,
  output logic           res_parity,
  output logic           res_odd,
  output logic           err,
  output logic           busy,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_sc,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_parity,
  input  logic           alu_odd
);

  localparam logic [OPW-1:0] OP_LIMIT = OPW'(MAX_OP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   sel_id;
  logic   arb_en;
  logic   arb_go;
  logic   arb_id;
  logic   illegal;

  // Both requesting: the one not served last time wins.
  always_comb begin
    arb_go = req0 | req1;
    arb_id = 1'b0;
    if (req0 && req1) arb_id = ~last_gnt;
    else if (req1)    arb_id = 1'b1;
  end

`ifdef ALU_ARB_BACK2BACK_EN
  assign arb_en = (state == IDLE) || (state == RESP);
`else
  assign arb_en = (state == IDLE);
`endif

  assign illegal = (alu_op > OP_LIMIT);
  assign alu_sc  = 1'b0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      sel_id     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      res        <= '0;
      res_zero   <= 1'b0;
      res_parity <= 1'b0;
      res_odd    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (arb_en && arb_go) begin
        alu_a    <= arb_id ? a1 : a0;
        alu_b    <= arb_id ? b1 : b0;
        alu_op   <= arb_id ? op1 : op0;
        gnt0     <= ~arb_id;
        gnt1     <= arb_id;
        last_gnt <= arb_id;
        sel_id   <= arb_id;
        busy     <= 1'b1;
        state    <= EXEC;
      end else begin
        case (state)
          EXEC: begin
            done    <= 1'b1;
            done_id <= sel_id;
            // Unsupported opcodes never expose the ALU output.
            if (illegal) begin
              res        <= '0;
              res_zero   <= 1'b0;
              res_parity <= 1'b0;
              res_odd    <= 1'b0;
              err        <= 1'b1;
            end else begin
              res        <= alu_out;
              res_zero   <= alu_zero;
              res_parity <= alu_parity;
              res_odd    <= alu_odd;
            end
            state <= RESP;
          end
          RESP: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
